// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: in-flight destination tracking, forwarding selects, load-use stall, branch kill and WB enable.
// Define PIPE_HAZARD_PERF_EN to add saturating stall/kill cycle counters.
module pipe_hazard_ctrl #(
  parameter int RA_W        = 5,
  parameter int FWD_DEPTH   = 3,
  parameter int FLUSH_DEPTH = 2,
  parameter int LOAD_LAT    = 1,
  parameter int SEL_W       = $clog2(FWD_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic             ex_branch_taken,
  output logic             stall,
  output logic             kill,
  output logic [SEL_W-1:0] fwd_sel1,
  output logic [SEL_W-1:0] fwd_sel2,
  output logic             wb_en,
  output logic [RA_W-1:0]  wb_rd
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]      perf_stall_cnt,
  output logic [31:0]      perf_kill_cnt
`endif
);
  localparam int CW = $clog2(FLUSH_DEPTH) + 1;
  logic [FWD_DEPTH-1:0] v, rw, ld;
  logic [FWD_DEPTH-1:0][RA_W-1:0] rd;
  logic [CW-1:0] flush_cnt;
  logic [SEL_W-1:0] s1, s2;
  logic hz1, hz2, issue;
  // Scan oldest to youngest so the youngest matching writer wins.
  always_comb begin
    s1 = '0;
    s2 = '0;
    hz1 = 1'b0;
    hz2 = 1'b0;
    for (int i = FWD_DEPTH - 1; i >= 0; i--) begin
      if (v[i] && rw[i] && rd[i] == id_rs1 && id_rs1 != '0 && id_rs1_used) begin
        s1 = SEL_W'(i + 1);
        hz1 = ld[i] && (i < LOAD_LAT);
      end
      if (v[i] && rw[i] && rd[i] == id_rs2 && id_rs2 != '0 && id_rs2_used) begin
        s2 = SEL_W'(i + 1);
        hz2 = ld[i] && (i < LOAD_LAT);
      end
    end
  end
  always_comb begin
    kill = rst | ex_branch_taken | (flush_cnt != '0);
    stall = ~kill & id_valid & (hz1 | hz2);
    issue = id_valid & ~kill & ~stall;
    fwd_sel1 = rst ? '0 : s1;
    fwd_sel2 = rst ? '0 : s2;
    wb_en = ~rst & v[FWD_DEPTH-1] & rw[FWD_DEPTH-1] & (rd[FWD_DEPTH-1] != '0);
    wb_rd = rst ? '0 : rd[FWD_DEPTH-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      rw <= '0;
      ld <= '0;
      rd <= '0;
      flush_cnt <= '0;
    end else begin
      v <= {v[FWD_DEPTH-2:0], issue};
      rw <= {rw[FWD_DEPTH-2:0], id_reg_write};
      ld <= {ld[FWD_DEPTH-2:0], id_is_load};
      rd <= {rd[FWD_DEPTH-2:0], id_rd};
      flush_cnt <= ex_branch_taken ? CW'(FLUSH_DEPTH - 1) :
                   (flush_cnt != '0) ? flush_cnt - CW'(1) : flush_cnt;
    end
  end
`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_kill_cnt <= '0;
    end else begin
      if (stall && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (kill && perf_kill_cnt != '1) perf_kill_cnt <= perf_kill_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for pipe_hazard_ctrl at default parameters.
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic v; logic [4:0] rs1; logic u1; logic [4:0] rs2; logic u2;
    logic [4:0] rd; logic rw; logic ld; logic br;
  } in_t;
  typedef struct packed {
    logic stall; logic kill; logic [1:0] s1; logic [1:0] s2; logic wb_en; logic [4:0] wb_rd;
  } out_t;
  logic clk = 0, rst = 0;
  logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_reg_write = 0, id_is_load = 0, ex_branch_taken = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic stall, kill, wb_en;
  logic [1:0] fwd_sel1, fwd_sel2;
  logic [4:0] wb_rd;
  int tests = 0, fails = 0;
  out_t exp_q[$];
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_kill_cnt;
`endif
  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .kill(kill), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .wb_en(wb_en), .wb_rd(wb_rd)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_kill_cnt(perf_kill_cnt)
`endif
  );
  always #5 clk = ~clk;
  function automatic in_t mi(logic v, logic [4:0] rs1, logic u1, logic [4:0] rs2, logic u2,
                             logic [4:0] rd, logic rw, logic ld, logic br);
    return '{v, rs1, u1, rs2, u2, rd, rw, ld, br};
  endfunction
  function automatic out_t mo(logic st, logic k, logic [1:0] s1, logic [1:0] s2, logic we, logic [4:0] r);
    return '{st, k, s1, s2, we, r};
  endfunction
  // wb_rd is only meaningful when wb_en is set, so it is masked otherwise.
  function automatic out_t obs();
    return '{stall, kill, fwd_sel1, fwd_sel2, wb_en, wb_en ? wb_rd : 5'd0};
  endfunction
  function automatic string fmt(out_t o);
    return $sformatf("stall=%b kill=%b sel1=%0d sel2=%0d wb_en=%b wb_rd=%0d", o.stall, o.kill, o.s1, o.s2, o.wb_en, o.wb_rd);
  endfunction
  task automatic drive(in_t s);
    id_valid = s.v; id_rs1 = s.rs1; id_rs1_used = s.u1; id_rs2 = s.rs2; id_rs2_used = s.u2;
    id_rd = s.rd; id_reg_write = s.rw; id_is_load = s.ld; ex_branch_taken = s.br;
  endtask
  task automatic idle(int n);
    for (int i = 0; i < n; i++) begin
      drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
    end
  endtask
  task automatic test_reset();
    out_t e, o;
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      drive(mi(1, 7, 1, 7, 1, 7, 1, 1, 0));
      exp_q.push_back(mo(0, 1, 0, 0, 0, 0));
      #2;
      e = exp_q.pop_front(); o = obs();
      tests++;
      if (o !== e || wb_rd !== 5'd0) begin
        fails++;
        $display("FAIL reset[%0d]: got %s raw_wb_rd=%0d, want %s raw_wb_rd=0", i, fmt(o), wb_rd, fmt(e));
      end
      @(negedge clk);
    end
    rst = 0;
    drive(mi(0, 0, 0, 0, 0, 0, 0, 0, 0));
    exp_q.push_back(mo(0, 0, 0, 0, 0, 0));
    #2;
    e = exp_q.pop_front(); o = obs();
    tests++;
    if (o !== e || wb_rd !== 5'd0) begin
      fails++;
      $display("FAIL post_reset: got %s raw_wb_rd=%0d, want %s raw_wb_rd=0", fmt(o), wb_rd, fmt(e));
    end
    @(negedge clk);
  endtask
  task automatic test_alu_chain();
    in_t si[5]; out_t so[5]; out_t e, o;
    si = '{mi(1, 0, 0, 0, 0, 5, 1, 0, 0), mi(1, 5, 1, 0, 0, 0, 0, 0, 0), mi(1, 5, 1, 0, 0, 0, 0, 0, 0),
           mi(1, 5, 1, 0, 0, 0, 0, 0, 0), mi(1, 5, 1, 0, 0, 0, 0, 0, 0)};
    so = '{mo(0, 0, 0, 0, 0, 0), mo(0, 0, 1, 0, 0, 0), mo(0, 0, 2, 0, 0, 0),
           mo(0, 0, 3, 0, 1, 5), mo(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 5; i++) begin
      drive(si[i]); exp_q.push_back(so[i]);
      #2;
      e = exp_q.pop_front(); o = obs();
      tests++;
      if (o !== e) begin fails++; $display("FAIL alu_chain[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      @(negedge clk);
    end
  endtask
  task automatic test_load_use();
    in_t si[4]; out_t so[4]; out_t e, o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] snap = perf_stall_cnt;
`endif
    si = '{mi(1, 0, 0, 0, 0, 7, 1, 1, 0), mi(1, 0, 0, 7, 1, 0, 0, 0, 0), mi(1, 0, 0, 7, 1, 0, 0, 0, 0),
           mi(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    so = '{mo(0, 0, 0, 0, 0, 0), mo(1, 0, 0, 1, 0, 0), mo(0, 0, 0, 2, 0, 0), mo(0, 0, 0, 0, 1, 7)};
    for (int i = 0; i < 4; i++) begin
      drive(si[i]); exp_q.push_back(so[i]);
      #2;
      e = exp_q.pop_front(); o = obs();
      tests++;
      if (o !== e) begin fails++; $display("FAIL load_use[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      @(negedge clk);
    end
`ifdef PIPE_HAZARD_PERF_EN
    tests++;
    if (perf_stall_cnt - snap !== 32'd1) begin
      fails++; $display("FAIL perf_stall: got delta %0d, want 1", perf_stall_cnt - snap);
    end
`endif
  endtask
  task automatic test_x0_unused();
    in_t si[8]; out_t so[8]; out_t e, o;
    si = '{mi(1, 0, 0, 0, 0, 0, 1, 1, 0), mi(1, 0, 1, 0, 0, 0, 0, 0, 0), mi(0, 0, 0, 0, 0, 0, 0, 0, 0),
           mi(0, 0, 0, 0, 0, 0, 0, 0, 0), mi(1, 0, 0, 0, 0, 4, 1, 0, 0), mi(1, 4, 0, 4, 1, 0, 0, 0, 0),
           mi(0, 0, 0, 0, 0, 0, 0, 0, 0), mi(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    so = '{mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0),
           mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 1, 0, 0), mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 4)};
    for (int i = 0; i < 8; i++) begin
      drive(si[i]); exp_q.push_back(so[i]);
      #2;
      e = exp_q.pop_front(); o = obs();
      tests++;
      if (o !== e) begin fails++; $display("FAIL x0_unused[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      @(negedge clk);
    end
  endtask
  task automatic test_youngest();
    in_t si[4]; out_t so[4]; out_t e, o;
    si = '{mi(1, 0, 0, 0, 0, 3, 1, 0, 0), mi(1, 0, 0, 0, 0, 3, 1, 0, 0), mi(1, 3, 1, 3, 1, 0, 0, 0, 0),
           mi(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    so = '{mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0), mo(0, 0, 1, 1, 0, 0), mo(0, 0, 0, 0, 1, 3)};
    for (int i = 0; i < 4; i++) begin
      drive(si[i]); exp_q.push_back(so[i]);
      #2;
      e = exp_q.pop_front(); o = obs();
      tests++;
      if (o !== e) begin fails++; $display("FAIL youngest[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      @(negedge clk);
    end
  endtask
  task automatic test_branch();
    in_t si[7]; out_t so[7]; out_t e, o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] snap = perf_kill_cnt;
`endif
    si = '{mi(1, 0, 0, 0, 0, 9, 1, 0, 0), mi(1, 0, 0, 0, 0, 10, 1, 0, 1), mi(1, 0, 0, 0, 0, 11, 1, 0, 0),
           mi(1, 0, 0, 0, 0, 12, 1, 0, 0), mi(0, 0, 0, 0, 0, 0, 0, 0, 0), mi(0, 0, 0, 0, 0, 0, 0, 0, 0),
           mi(0, 0, 0, 0, 0, 0, 0, 0, 0)};
    so = '{mo(0, 0, 0, 0, 0, 0), mo(0, 1, 0, 0, 0, 0), mo(0, 1, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 9),
           mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 1, 12)};
    for (int i = 0; i < 7; i++) begin
      drive(si[i]); exp_q.push_back(so[i]);
      #2;
      e = exp_q.pop_front(); o = obs();
      tests++;
      if (o !== e) begin fails++; $display("FAIL branch[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      @(negedge clk);
    end
`ifdef PIPE_HAZARD_PERF_EN
    tests++;
    if (perf_kill_cnt - snap !== 32'd2) begin
      fails++; $display("FAIL perf_kill: got delta %0d, want 2", perf_kill_cnt - snap);
    end
`endif
  endtask
  task automatic test_reset_midflight();
    in_t si[7]; out_t so[7]; out_t e, o;
    si = '{mi(1, 0, 0, 0, 0, 1, 1, 0, 0), mi(1, 0, 0, 0, 0, 2, 1, 0, 0), mi(1, 0, 0, 0, 0, 3, 1, 0, 0),
           mi(1, 0, 0, 0, 0, 4, 1, 0, 0), mi(1, 3, 1, 2, 1, 0, 0, 0, 0), mi(1, 1, 1, 3, 1, 0, 0, 0, 0),
           mi(1, 2, 1, 1, 1, 0, 0, 0, 0)};
    so = '{mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0), mo(0, 1, 0, 0, 0, 0),
           mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0), mo(0, 0, 0, 0, 0, 0)};
    for (int i = 0; i < 7; i++) begin
      rst = (i == 3);
      drive(si[i]); exp_q.push_back(so[i]);
      #2;
      e = exp_q.pop_front(); o = obs();
      tests++;
      if (o !== e) begin fails++; $display("FAIL reset_midflight[%0d]: got %s, want %s", i, fmt(o), fmt(e)); end
      @(negedge clk);
    end
    rst = 0;
`ifdef PIPE_HAZARD_PERF_EN
    tests++;
    if (perf_stall_cnt !== 32'd0 || perf_kill_cnt !== 32'd0) begin
      fails++; $display("FAIL perf_reset: got stall=%0d kill=%0d, want 0 0", perf_stall_cnt, perf_kill_cnt);
    end
`endif
  endtask
  initial begin
    @(negedge clk);
    test_reset();
    idle(3);
    test_alu_chain();
    idle(3);
    test_load_use();
    idle(3);
    test_x0_unused();
    idle(3);
    test_youngest();
    idle(3);
    test_branch();
    idle(3);
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
